// File: rtl/coin_input_conditioner.sv
// Synchronises and debounces the coin push-buttons and product switches, turning each
// accepted coin press into one coin code held for HOLD_CYCLES clocks, and filtering the switches to legal one-hot codes.
module coin_input_conditioner #(
   parameter logic [23:0] DEBOUNCE_CYCLES = 24'd1000000,
   parameter logic [23:0] HOLD_CYCLES     = 24'h200000
) (
   input  logic       clock,
   input  logic       reset,
   input  logic [2:0] raw_button,
   input  logic [3:0] raw_switch,
   output logic [2:0] button,
   output logic [3:0] switch,
   output logic       busy
);

   localparam logic [23:0] DB_LAST   = DEBOUNCE_CYCLES - 24'd1;
   localparam logic [23:0] HOLD_LAST = HOLD_CYCLES - 24'd1;

   typedef enum logic [1:0] {IDLE, HOLD, GAP, RELEASE} state_t;

   logic [2:0]  btn_meta, btn_sync, btn_cand, btn_stable;
   logic [3:0]  sw_meta, sw_sync, sw_cand, sw_stable;
   logic [23:0] btn_cnt, sw_cnt;

   state_t      state, state_n;
   logic [23:0] t, t_n;
   logic [2:0]  code, code_n, button_n;
   logic        busy_n;

   function automatic logic onehot3(input logic [2:0] v);
      return (v != 3'd0) && ((v & (v - 3'd1)) == 3'd0);
   endfunction

   function automatic logic onehot4(input logic [3:0] v);
      return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
   endfunction

   always_ff @(posedge clock) begin
      if (reset) begin
         btn_meta <= '0;
         btn_sync <= '0;
         sw_meta  <= '0;
         sw_sync  <= '0;
      end else begin
         btn_meta <= raw_button;
         btn_sync <= btn_meta;
         sw_meta  <= raw_switch;
         sw_sync  <= sw_meta;
      end
   end

   // Counter holds at DB_LAST once reached, so a long-stable input never wraps.
   always_ff @(posedge clock) begin
      if (reset) begin
         btn_cand   <= '0;
         btn_cnt    <= '0;
         btn_stable <= '0;
      end else if (btn_sync != btn_cand) begin
         btn_cand <= btn_sync;
         btn_cnt  <= '0;
      end else if (btn_cnt == DB_LAST) begin
         btn_stable <= btn_cand;
      end else begin
         btn_cnt <= btn_cnt + 24'd1;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         sw_cand   <= '0;
         sw_cnt    <= '0;
         sw_stable <= '0;
      end else if (sw_sync != sw_cand) begin
         sw_cand <= sw_sync;
         sw_cnt  <= '0;
      end else if (sw_cnt == DB_LAST) begin
         sw_stable <= sw_cand;
      end else begin
         sw_cnt <= sw_cnt + 24'd1;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         switch <= '0;
      end else begin
         switch <= onehot4(sw_stable) ? sw_stable : 4'd0;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state  <= IDLE;
         t      <= '0;
         code   <= '0;
         button <= '0;
         busy   <= 1'b0;
      end else begin
         state  <= state_n;
         t      <= t_n;
         code   <= code_n;
         button <= button_n;
         busy   <= busy_n;
      end
   end

   // Outputs are computed as next-state values so button/busy are registered with the state.
   always_comb begin
      state_n  = state;
      t_n      = t;
      code_n   = code;
      button_n = 3'd0;
      case (state)
         IDLE: begin
            if (onehot3(btn_stable)) begin
               code_n   = btn_stable;
               button_n = btn_stable;
               t_n      = '0;
               state_n  = HOLD;
            end else if (btn_stable != 3'd0) begin
               state_n = RELEASE;
            end
         end
         HOLD: begin
            button_n = code;
            if (t == HOLD_LAST) begin
               button_n = 3'd0;
               t_n      = '0;
               state_n  = GAP;
            end else begin
               t_n = t + 24'd1;
            end
         end
         GAP: begin
            if (t == HOLD_LAST) begin
               state_n = RELEASE;
            end else begin
               t_n = t + 24'd1;
            end
         end
         RELEASE: begin
            if (btn_stable == 3'd0) begin
               state_n = IDLE;
            end
         end
         default: state_n = IDLE;
      endcase
      busy_n = (state_n != IDLE);
   end

endmodule

// File: tb/tb_coin_input_conditioner.sv
// Directed bench for coin_input_conditioner with DEBOUNCE_CYCLES=4, HOLD_CYCLES=8:
// a vector table for reset and switch behaviour, then watched coin-press sequences.
module tb_coin_input_conditioner;

   logic       clock = 1'b0;
   logic       reset;
   logic [2:0] raw_button;
   logic [3:0] raw_switch;
   logic [2:0] button;
   logic [3:0] switch;
   logic       busy;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clock = ~clock;

   coin_input_conditioner #(
      .DEBOUNCE_CYCLES(24'd4),
      .HOLD_CYCLES    (24'd8)
   ) dut (
      .clock     (clock),
      .reset     (reset),
      .raw_button(raw_button),
      .raw_switch(raw_switch),
      .button    (button),
      .switch    (switch),
      .busy      (busy)
   );

   typedef struct {
      logic       rst;
      logic [2:0] rb;
      logic [3:0] rs;
      int         cycles;
      logic [2:0] eb;
      logic [3:0] es;
      logic       ebusy;
   } vec_t;

   vec_t vecs[21];

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // Drives one coin pattern for n clocks and records what appears on button/busy.
   // Edge i is the i-th rising edge after the call; raw input for edge i is set just before it.
   task automatic watch(input logic [2:0] code, input int bounce_len, input int release_at,
                        input int n, output int first, output int width, output int pulses,
                        output int val, output int busy_first, output int busy_last);
      logic [2:0] prev;
      first = -1; width = 0; pulses = 0; val = 0; busy_first = -1; busy_last = -1;
      prev = button;
      for (int i = 1; i <= n; i++) begin
         if (i <= bounce_len)
            raw_button = (((i - 1) / 2) % 2 == 0) ? code : 3'd0;
         else if (i <= release_at)
            raw_button = code;
         else
            raw_button = 3'd0;
         @(negedge clock);
         if (button != 3'd0) begin
            width++;
            if (prev == 3'd0) begin
               pulses++;
               if (first < 0) begin
                  first = i;
                  val   = int'(button);
               end
            end
         end
         if (busy) begin
            if (busy_first < 0) busy_first = i;
            busy_last = i;
         end
         prev = button;
      end
   endtask

   task automatic check_press(input string name, input logic [2:0] code, input int bounce_len,
                              input int release_at, input int n, input int e_first,
                              input int e_pulses, input int e_val, input int e_bfirst,
                              input int e_blast);
      int first, width, pulses, val, bfirst, blast;
      watch(code, bounce_len, release_at, n, first, width, pulses, val, bfirst, blast);
      chk({name, " pulse start"}, first, e_first);
      chk({name, " pulse count"}, pulses, e_pulses);
      chk({name, " pulse width"}, width, (e_pulses > 0) ? 8 : 0);
      chk({name, " code"}, val, e_val);
      chk({name, " busy rise"}, bfirst, e_bfirst);
      chk({name, " busy last"}, blast, e_blast);
   endtask

   initial begin
      //            rst   rb    rs    cyc  button switch busy
      vecs[0]  = '{1'b1, 3'd2, 4'd8, 1,  3'd0, 4'd0, 1'b0};
      vecs[1]  = '{1'b1, 3'd2, 4'd8, 1,  3'd0, 4'd0, 1'b0};
      vecs[2]  = '{1'b0, 3'd2, 4'd8, 7,  3'd0, 4'd0, 1'b0};
      vecs[3]  = '{1'b0, 3'd0, 4'd8, 1,  3'd2, 4'd8, 1'b1};
      vecs[4]  = '{1'b0, 3'd0, 4'd8, 7,  3'd2, 4'd8, 1'b1};
      vecs[5]  = '{1'b0, 3'd0, 4'd8, 1,  3'd0, 4'd8, 1'b1};
      vecs[6]  = '{1'b0, 3'd0, 4'd8, 8,  3'd0, 4'd8, 1'b1};
      vecs[7]  = '{1'b0, 3'd0, 4'd8, 1,  3'd0, 4'd8, 1'b0};
      vecs[8]  = '{1'b0, 3'd0, 4'd4, 7,  3'd0, 4'd8, 1'b0};
      vecs[9]  = '{1'b0, 3'd0, 4'd4, 1,  3'd0, 4'd4, 1'b0};
      vecs[10] = '{1'b0, 3'd0, 4'd6, 7,  3'd0, 4'd4, 1'b0};
      vecs[11] = '{1'b0, 3'd0, 4'd6, 1,  3'd0, 4'd0, 1'b0};
      vecs[12] = '{1'b0, 3'd0, 4'd4, 8,  3'd0, 4'd4, 1'b0};
      vecs[13] = '{1'b0, 3'd0, 4'd1, 3,  3'd0, 4'd4, 1'b0};
      vecs[14] = '{1'b0, 3'd0, 4'd4, 10, 3'd0, 4'd4, 1'b0};
      vecs[15] = '{1'b0, 3'd0, 4'd1, 4,  3'd0, 4'd4, 1'b0};
      vecs[16] = '{1'b0, 3'd0, 4'd4, 10, 3'd0, 4'd4, 1'b0};
      vecs[17] = '{1'b0, 3'd0, 4'd2, 5,  3'd0, 4'd4, 1'b0};
      vecs[18] = '{1'b0, 3'd0, 4'd4, 3,  3'd0, 4'd2, 1'b0};
      vecs[19] = '{1'b0, 3'd0, 4'd4, 4,  3'd0, 4'd2, 1'b0};
      vecs[20] = '{1'b0, 3'd0, 4'd4, 1,  3'd0, 4'd4, 1'b0};

      reset      = 1'b1;
      raw_button = 3'd2;
      raw_switch = 4'd8;

      for (int v = 0; v < 21; v++) begin
         reset      = vecs[v].rst;
         raw_button = vecs[v].rb;
         raw_switch = vecs[v].rs;
         repeat (vecs[v].cycles) @(negedge clock);
         chk($sformatf("vec%0d button", v), int'(button), int'(vecs[v].eb));
         chk($sformatf("vec%0d switch", v), int'(switch), int'(vecs[v].es));
         chk($sformatf("vec%0d busy", v), int'(busy), int'(vecs[v].ebusy));
      end

      //          name      code  bounce rel  n   first pulses val bfirst blast
      check_press("dime",    3'd2, 0,  40, 70, 8,  1, 2, 8,  47);
      check_press("bounce",  3'd1, 20, 50, 80, 28, 1, 1, 28, 57);
      check_press("illegal", 3'd5, 0,  30, 50, -1, 0, 0, 8,  37);
      check_press("quarter", 3'd4, 0,  30, 50, 8,  1, 4, 8,  37);

      // Reset during the third clock of a quarter pulse, released press.
      raw_button = 3'd4;
      repeat (8) @(negedge clock);
      chk("midhold pulse edge8", int'(button), 4);
      repeat (2) @(negedge clock);
      chk("midhold pulse edge10", int'(button), 4);
      reset      = 1'b1;
      raw_button = 3'd0;
      @(negedge clock);
      chk("midhold reset button", int'(button), 0);
      chk("midhold reset busy", int'(busy), 0);
      chk("midhold reset switch", int'(switch), 0);
      @(negedge clock);
      reset = 1'b0;
      check_press("after reset", 3'd0, 0, 0, 30, -1, 0, 0, -1, -1);
      check_press("dime again", 3'd2, 0, 40, 70, 8, 1, 2, 8, 47);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
